hi_lo_mult_div_unit: RTL and testbench

- Owns the architectural HI and LO registers.
- Executes MULT, MULTU, DIV and DIVU as 32-iteration sequential operations, and MTHI/MTLO as single-cycle writes.
- Sits directly upstream of the register-file output mux: HI_data_reg and LO_data_reg feed that mux's HI/LO inputs, which serve MFHI/MFLO.
- busy drives the hazard unit, which stalls any HI/LO reader or new mult/div issue while an operation is in flight.

---
 rtl/hi_lo_mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_hi_lo_mult_div_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hi_lo_mult_div_unit.sv
// HI/LO owner: sequential 32-step multiply/divide plus MTHI/MTLO writes.
// HI/LO change only on commit, so readers never see partial results.
module hi_lo_mult_div_unit #(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] HI_data_reg,
  output logic [31:0] LO_data_reg,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(ITERATIONS + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   acc_q;
  logic [31:0]   b_q;
  logic [31:0]   a_raw_q;
  logic          neg_q;
  logic          rneg_q;
  logic          dz_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          busy_q;
  logic          done_q;

  logic          sgn;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [32:0]   sum;
  logic [32:0]   trial;
  logic [32:0]   diff;
  logic [63:0]   mul_d;
  logic [63:0]   div_d;
  logic [63:0]   prod;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic          last;

  always_comb begin
    sgn   = ~op[0];
    mag_a = (sgn && operand_a[31]) ? -operand_a : operand_a;
    mag_b = (sgn && operand_b[31]) ? -operand_b : operand_b;
    // Multiply: {hi,lo} accumulator, multiplier shifts out of lo.
    sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_d = {sum, acc_q[31:1]};
    // Divide: {rem,dividend}; borrow in diff[32] means trial < divisor.
    trial = {acc_q[63:32], acc_q[31]};
    diff  = trial - {1'b0, b_q};
    div_d = diff[32] ? {trial[31:0], acc_q[30:0], 1'b0}
                     : {diff[31:0], acc_q[30:0], 1'b1};
    prod  = neg_q  ? -mul_d : mul_d;
    quo   = neg_q  ? -div_d[31:0] : div_d[31:0];
    rem   = rneg_q ? -div_d[63:32] : div_d[63:32];
    last  = (cnt_q == CW'(ITERATIONS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      a_raw_q <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                state_q <= MUL;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                acc_q   <= {32'd0, mag_b};
                b_q     <= mag_a;
                neg_q   <= sgn & (operand_a[31] ^ operand_b[31]);
                rneg_q  <= 1'b0;
                dz_q    <= 1'b0;
              end
              3'b010, 3'b011: begin
                state_q <= DIV;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                acc_q   <= {32'd0, mag_a};
                b_q     <= mag_b;
                a_raw_q <= operand_a;
                neg_q   <= sgn & (operand_a[31] ^ operand_b[31]);
                rneg_q  <= sgn & operand_a[31];
                dz_q    <= (operand_b == 32'd0);
              end
              3'b100: begin
                hi_q   <= operand_a;
                done_q <= 1'b1;
              end
              3'b101: begin
                lo_q   <= operand_a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc_q <= mul_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        DIV: begin
          acc_q <= div_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            // Divide by zero still runs full length, then reports a / all-ones.
            hi_q    <= dz_q ? a_raw_q : rem;
            lo_q    <= dz_q ? 32'hFFFF_FFFF : quo;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HI_data_reg = hi_q;
  assign LO_data_reg = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_hi_lo_mult_div_unit.sv
// Bench for hi_lo_mult_div_unit: directed vectors, corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_hi_lo_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] HI_data_reg;
  logic [31:0] LO_data_reg;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hi_lo_mult_div_unit #(.ITERATIONS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .HI_data_reg(HI_data_reg),
    .LO_data_reg(LO_data_reg),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin
        p = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      3'd3: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] ph;
    logic [31:0] pl;
    int n;
    bit held;
    ph = HI_data_reg;
    pl = LO_data_reg;
    held = 1'b1;
    @(negedge clk);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    model(o, a, b);
    if (o < 3'd4) begin
      n = 0;
      while (busy && n < 40) begin
        if (HI_data_reg !== ph || LO_data_reg !== pl) held = 1'b0;
        @(posedge clk);
        #1;
        n++;
      end
      chk("busy_cycles", 64'(n), 64'd32);
      chk("hilo_held", 64'(held), 64'd1);
      chk("done_rise", 64'(done), 64'd1);
      chk("hi", 64'(HI_data_reg), 64'(m_hi));
      chk("lo", 64'(LO_data_reg), 64'(m_lo));
      @(posedge clk);
      #1;
      chk("done_fall", 64'(done), 64'd0);
    end else if (o < 3'd6) begin
      chk("mt_busy", 64'(busy), 64'd0);
      chk("mt_done", 64'(done), 64'd1);
      chk("mt_hi", 64'(HI_data_reg), 64'(m_hi));
      chk("mt_lo", 64'(LO_data_reg), 64'(m_lo));
      @(posedge clk);
      #1;
      chk("mt_done_fall", 64'(done), 64'd0);
    end else begin
      chk("nop_busy", 64'(busy), 64'd0);
      chk("nop_done", 64'(done), 64'd0);
      chk("nop_hilo", {HI_data_reg, LO_data_reg}, {m_hi, m_lo});
    end
  endtask

  vec_t vecs[$];

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{3'd3, 32'd100, 32'd7, 32'd2, 32'd14});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000});
    vecs.push_back('{3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF});
    vecs.push_back('{3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
    vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});

    #2;
    chk("rst_hi", 64'(HI_data_reg), 64'd0);
    chk("rst_lo", 64'(LO_data_reg), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_hi", i), 64'(HI_data_reg), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(LO_data_reg), 64'(vecs[i].lo));
    end

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1;
    op = 3'd4;
    operand_a = 32'h1234_5678;
    @(posedge clk);
    #1;
    model(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", 64'(HI_data_reg), 64'h1234_5678);
    chk("mthi_lo", 64'(LO_data_reg), 64'(m_lo));
    chk("mthi_done", 64'(done), 64'd1);
    chk("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    op = 3'd5;
    operand_a = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    start = 1'b0;
    model(3'd5, 32'hCAFE_BABE, 32'd0);
    chk("mtlo_lo", 64'(LO_data_reg), 64'hCAFE_BABE);
    chk("mtlo_hi", 64'(HI_data_reg), 64'h1234_5678);
    chk("mtlo_done", 64'(done), 64'd1);
    chk("mtlo_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("mt_done_fall", 64'(done), 64'd0);

    // DIVU and MTLO pulsed mid-MULTU must be ignored
    @(negedge clk);
    start = 1'b1;
    op = 3'd1;
    operand_a = 32'h0001_0003;
    operand_b = 32'h0002_0005;
    @(posedge clk);
    #1;
    start = 1'b0;
    model(3'd1, 32'h0001_0003, 32'h0002_0005);
    n = 0;
    while (busy && n < 40) begin
      if (n == 9) begin
        @(negedge clk);
        start = 1'b1;
        op = 3'd3;
        operand_a = 32'd99;
        operand_b = 32'd4;
      end else if (n == 10) begin
        @(negedge clk);
        op = 3'd5;
        operand_a = 32'hDEAD_BEEF;
      end else if (n == 11) begin
        @(negedge clk);
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("ign_cycles", 64'(n), 64'd32);
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_hi", 64'(HI_data_reg), 64'(m_hi));
    chk("ign_lo", 64'(LO_data_reg), 64'(m_lo));
    run_op(3'd3, 32'd99, 32'd4);

    // Asynchronous reset during iteration 17 of a DIV
    @(negedge clk);
    start = 1'b1;
    op = 3'd2;
    operand_a = 32'hFFFF_0000;
    operand_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_hi", 64'(HI_data_reg), 64'd0);
    chk("arst_lo", 64'(LO_data_reg), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 32'hFFFF_FF00, 32'd12345);

    // Randomized ops against the reference model
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(ro, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
